// File: rtl/control32_mc.sv
// control32_mc: multi-cycle control unit for the minisys datapath.
// Five-state IF/ID/EX/MEM/WB sequencer with I/O window, wait states and bus timeout.
module control32_mc #(
    parameter int                     ADDR_HIGH_W = 22,
    parameter logic [ADDR_HIGH_W-1:0] IO_HIGH     = {ADDR_HIGH_W{1'b1}},
    parameter int                     TIMEOUT     = 15
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Function_opcode,
    input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
    input  logic                   Zero,
    input  logic                   Mem_ready,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic [1:0]             PCSrc,
    output logic [1:0]             RegDST,
    output logic                   ALUSrc,
    output logic [1:0]             ALUOp,
    output logic                   Sftmd,
    output logic                   I_format,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IORead,
    output logic                   IOWrite,
    output logic                   MemorIOtoReg,
    output logic                   RegWrite,
    output logic                   Bus_error,
    output logic                   Illegal,
    output logic [2:0]             State
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Last wait count before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;

    // Instruction class decode.
    logic r_fmt;
    logic jr_op;
    logic j_op;
    logic jal_op;
    logic beq_op;
    logic bne_op;
    logic lw_op;
    logic sw_op;
    logic i_fmt;
    logic legal;
    logic io_sel;

    // Unqualified control values; gated by reset_n on the way out.
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       sftmd;
    logic       i_fmt_o;
    logic       mem_read;
    logic       mem_write;
    logic       io_read;
    logic       io_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       bus_err;
    logic       illegal;

    // Opcode/function decode and I/O window compare.
    always_comb begin
        r_fmt  = (Opcode == 6'b000000);
        jr_op  = r_fmt && (Function_opcode == 6'b001000);
        j_op   = (Opcode == 6'b000010);
        jal_op = (Opcode == 6'b000011);
        beq_op = (Opcode == 6'b000100);
        bne_op = (Opcode == 6'b000101);
        lw_op  = (Opcode == 6'b100011);
        sw_op  = (Opcode == 6'b101011);
        i_fmt  = (Opcode[5:3] == 3'b001);
        legal  = r_fmt | j_op | jal_op | beq_op | bne_op
               | lw_op | sw_op | i_fmt;
        io_sel = (Alu_resultHigh == IO_HIGH);
    end

    // State register and MEM wait counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = 8'd0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 2'd0;
        sftmd      = 1'b0;
        i_fmt_o    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        io_read    = 1'b0;
        io_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        bus_err    = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                pc_src   = 2'd0;
                state_d  = S_ID;
            end
            S_ID: begin
                if (j_op) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    state_d  = S_IF;
                end else if (jal_op) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    state_d   = S_IF;
                end else if (jr_op) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                    state_d  = S_IF;
                end else if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src = i_fmt | lw_op | sw_op;
                alu_op  = {r_fmt | i_fmt, beq_op | bne_op};
                sftmd   = r_fmt && (Function_opcode[5:3] == 3'b000);
                i_fmt_o = i_fmt;
                if (beq_op) begin
                    pc_write = Zero;
                    pc_src   = 2'd1;
                    state_d  = S_IF;
                end else if (bne_op) begin
                    pc_write = !Zero;
                    pc_src   = 2'd1;
                    state_d  = S_IF;
                end else if (lw_op || sw_op) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = lw_op && !io_sel;
                io_read   = lw_op && io_sel;
                mem_write = sw_op && !io_sel;
                io_write  = sw_op && io_sel;
                if (Mem_ready) begin
                    wait_d  = 8'd0;
                    state_d = lw_op ? S_WB : S_IF;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err = 1'b1;
                    wait_d  = 8'd0;
                    state_d = S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = r_fmt ? 2'd1 : 2'd0;
                mem_to_reg = lw_op;
                state_d    = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Reset forces every strobe low immediately, including mid-access.
    always_comb begin
        IRWrite      = reset_n & ir_write;
        PCWrite      = reset_n & pc_write;
        PCSrc        = reset_n ? pc_src : 2'd0;
        RegDST       = reset_n ? reg_dst : 2'd0;
        ALUSrc       = reset_n & alu_src;
        ALUOp        = reset_n ? alu_op : 2'd0;
        Sftmd        = reset_n & sftmd;
        I_format     = reset_n & i_fmt_o;
        MemRead      = reset_n & mem_read;
        MemWrite     = reset_n & mem_write;
        IORead       = reset_n & io_read;
        IOWrite      = reset_n & io_write;
        MemorIOtoReg = reset_n & mem_to_reg;
        RegWrite     = reset_n & reg_write;
        Bus_error    = reset_n & bus_err;
        Illegal      = reset_n & illegal;
        State        = state_q;
    end

endmodule

// File: tb/tb_control32_mc.sv
// tb_control32_mc: scoreboard bench for control32_mc.
// Per-cycle stimulus and expected controls are queued, then replayed and compared.
module tb_control32_mc;

    typedef struct packed {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic [1:0] regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       sftmd;
        logic       ifmt;
        logic       mr;
        logic       mw;
        logic       ior;
        logic       iow;
        logic       m2r;
        logic       be;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [21:0] hi;
        logic        z;
        logic        rdy;
    } stim_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  Opcode = 6'd0;
    logic [5:0]  Function_opcode = 6'd0;
    logic [21:0] Alu_resultHigh = 22'd0;
    logic        Zero = 1'b0;
    logic        Mem_ready = 1'b0;
    logic        IRWrite, PCWrite, ALUSrc, Sftmd, I_format;
    logic        MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg;
    logic        RegWrite, Bus_error, Illegal;
    logic [1:0]  PCSrc, RegDST, ALUOp;
    logic [2:0]  State;
    exp_t        obs;

    int checks = 0;
    int errors = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    control32_mc dut (
        .clock(clock), .reset_n(reset_n), .Opcode(Opcode),
        .Function_opcode(Function_opcode), .Alu_resultHigh(Alu_resultHigh),
        .Zero(Zero), .Mem_ready(Mem_ready), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDST(RegDST), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .Sftmd(Sftmd), .I_format(I_format),
        .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead),
        .IOWrite(IOWrite), .MemorIOtoReg(MemorIOtoReg),
        .RegWrite(RegWrite), .Bus_error(Bus_error), .Illegal(Illegal),
        .State(State)
    );

    always #5 clock = ~clock;

    assign obs = exp_t'({State, IRWrite, PCWrite, PCSrc, RegWrite, RegDST,
                         ALUSrc, ALUOp, Sftmd, I_format, MemRead, MemWrite,
                         IORead, IOWrite, MemorIOtoReg, Bus_error, Illegal});

    function automatic stim_t sti(logic [5:0] op, logic [5:0] fn,
                                  logic [21:0] hi, logic z, logic rdy);
        stim_t s;
        s.op = op; s.fn = fn; s.hi = hi; s.z = z; s.rdy = rdy;
        return s;
    endfunction

    function automatic exp_t st(logic [2:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t e_if();
        exp_t e;
        e = st(3'd0);
        e.irw = 1'b1;
        e.pcw = 1'b1;
        return e;
    endfunction

    task automatic push(stim_t s, exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(stim_t s);
        Opcode = s.op;
        Function_opcode = s.fn;
        Alu_resultHigh = s.hi;
        Zero = s.z;
        Mem_ready = s.rdy;
    endtask

    task automatic test_reset();
        exp_t e;
        int n = 0;
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (obs !== st(3'd0)) begin
                errors++;
                $display("FAIL reset_hold got %h exp %h", obs, st(3'd0));
            end
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        apply(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0));
        @(negedge clock);
        checks++;
        if (obs !== e_if()) begin
            errors++;
            $display("FAIL reset_first_if got %h exp %h", obs, e_if());
        end
        e = st(3'd1); e.pcw = 1'b1; e.pcsrc = 2'd2;
        push(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0), e);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_j cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_rtype();
        exp_t  e;
        stim_t s;
        int    n = 0;
        // add
        s = sti(6'b000000, 6'b100000, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.aluop = 2'b10; push(s, e);
        e = st(3'd4); e.regw = 1'b1; e.regdst = 2'd1; push(s, e);
        // sll
        s = sti(6'b000000, 6'b000000, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.aluop = 2'b10; e.sftmd = 1'b1; push(s, e);
        e = st(3'd4); e.regw = 1'b1; e.regdst = 2'd1; push(s, e);
        // jr
        s = sti(6'b000000, 6'b001000, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        e = st(3'd1); e.pcw = 1'b1; e.pcsrc = 2'd3; push(s, e);
        // addi
        s = sti(6'b001000, 6'b100000, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.alusrc = 1'b1; e.aluop = 2'b10; e.ifmt = 1'b1;
        push(s, e);
        e = st(3'd4); e.regw = 1'b1; push(s, e);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rtype cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_lw();
        exp_t  e;
        stim_t s;
        int    n = 0;
        for (int k = 0; k < 2; k++) begin
            logic [21:0] hi;
            hi = (k == 0) ? 22'h3FFFFF : 22'h000001;
            s = sti(6'b100011, 6'd0, hi, 1'b0, 1'b0);
            push(s, e_if());
            push(s, st(3'd1));
            e = st(3'd2); e.alusrc = 1'b1; push(s, e);
            for (int c = 0; c < 4; c++) begin
                e = st(3'd3);
                e.ior = (k == 0);
                e.mr = (k != 0);
                push(sti(6'b100011, 6'd0, hi, 1'b0, c == 3), e);
            end
            e = st(3'd4); e.regw = 1'b1; e.m2r = 1'b1; push(s, e);
        end
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lw cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        exp_t  e;
        stim_t s;
        int    n = 0;
        s = sti(6'b101011, 6'd0, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.alusrc = 1'b1; push(s, e);
        for (int c = 0; c < 15; c++) begin
            e = st(3'd3); e.mw = 1'b1; e.be = (c == 14);
            push(s, e);
        end
        // back in IF right after the timeout
        push(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0), e_if());
        e = st(3'd1); e.pcw = 1'b1; e.pcsrc = 2'd2;
        push(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0), e);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        exp_t  e;
        stim_t s;
        int    n = 0;
        for (int k = 0; k < 4; k++) begin
            logic [5:0] op;
            logic       z;
            op = (k < 2) ? 6'b000100 : 6'b000101;
            z = (k % 2 == 0);
            s = sti(op, 6'd0, 22'd0, z, 1'b0);
            push(s, e_if());
            push(s, st(3'd1));
            e = st(3'd2); e.aluop = 2'b01; e.pcsrc = 2'd1;
            e.pcw = (k < 2) ? z : !z;
            push(s, e);
        end
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_jump();
        exp_t  e;
        stim_t s;
        int    n = 0;
        s = sti(6'b000011, 6'd0, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        e = st(3'd1); e.pcw = 1'b1; e.pcsrc = 2'd2;
        e.regw = 1'b1; e.regdst = 2'd2;
        push(s, e);
        s = sti(6'b111111, 6'd0, 22'd0, 1'b0, 1'b1);
        push(s, e_if());
        e = st(3'd1); e.ill = 1'b1; push(s, e);
        s = sti(6'b010000, 6'd0, 22'd0, 1'b0, 1'b0);
        push(s, e_if());
        e = st(3'd1); e.ill = 1'b1; push(s, e);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL jump cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        stim_t s;
        int    n = 0;
        // sw to I/O, ready at once
        s = sti(6'b101011, 6'd0, 22'h3FFFFF, 1'b0, 1'b1);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.alusrc = 1'b1; push(s, e);
        e = st(3'd3); e.iow = 1'b1; push(s, e);
        // lw to memory, interrupted by reset in MEM
        s = sti(6'b100011, 6'd0, 22'h000001, 1'b0, 1'b0);
        push(s, e_if());
        push(s, st(3'd1));
        e = st(3'd2); e.alusrc = 1'b1; push(s, e);
        e = st(3'd3); e.mr = 1'b1; push(s, e);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== st(3'd0)) begin
            errors++;
            $display("FAIL mid_mem_reset got %h exp %h", obs, st(3'd0));
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        apply(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0));
        @(negedge clock);
        checks++;
        if (obs !== e_if()) begin
            errors++;
            $display("FAIL post_reset_if got %h exp %h", obs, e_if());
        end
        e = st(3'd1); e.pcw = 1'b1; e.pcsrc = 2'd2;
        push(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0), e);
        push(sti(6'b000010, 6'd0, 22'd0, 1'b0, 1'b0), e_if());
        n = 0;
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b_tail cyc %0d got %h exp %h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_timeout();
        test_branch();
        test_jump();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
